// File: rtl/tmds_channel_rx.sv
// TMDS channel receiver: word alignment by control-token search plus 10b->8b decode.
// A two-word history lets any of the ten bit phases be selected. A small FSM either
// searches for a run of control tokens or monitors an established lock. The decoded
// outputs are registered one stage after the aligned word.
module tmds_channel_rx #(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOCK_TIMEOUT   = 2048
) (
  input  logic       pixclk,
  input  logic       resetn,
  input  logic [9:0] raw,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       vde,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int RUN_W = (CTRL_RUN > 1) ? $clog2(CTRL_RUN) : 1;
  localparam int TMO_W = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;
  localparam int NOC_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  localparam logic [9:0] TOK_C00 = 10'b1101010100;
  localparam logic [9:0] TOK_C01 = 10'b0010101011;
  localparam logic [9:0] TOK_C10 = 10'b0101010100;
  localparam logic [9:0] TOK_C11 = 10'b1010101011;

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // True when the word is one of the four control tokens.
  function automatic logic is_token(input logic [9:0] w);
    logic hit;
    case (w)
      TOK_C00, TOK_C01, TOK_C10, TOK_C11: hit = 1'b1;
      default:                            hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Control bits {C1,C0} carried by a token; zero for anything else.
  function automatic logic [1:0] token_value(input logic [9:0] w);
    logic [1:0] v;
    case (w)
      TOK_C00: v = 2'b00;
      TOK_C01: v = 2'b01;
      TOK_C10: v = 2'b10;
      TOK_C11: v = 2'b11;
      default: v = 2'b00;
    endcase
    return v;
  endfunction

  // Undo the optional inversion (bit 9), then the XOR/XNOR transition chain (bit 8).
  function automatic logic [7:0] decode_word(input logic [9:0] w);
    logic [7:0] q;
    logic [7:0] d;
    q    = w[7:0] ^ {8{w[9]}};
    d    = 8'h00;
    d[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return d;
  endfunction

  state_e           state_q, state_d;
  logic [9:0]       prev_q;
  logic [9:0]       win_q;
  logic [9:0]       win_s;
  logic [19:0]      cat_s;
  logic [RUN_W-1:0] run_q, run_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [NOC_W-1:0] noc_q, noc_d;
  logic [3:0]       offset_q, offset_d;
  logic [7:0]       data_q, data_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic             vde_q, vde_d;
  logic             locked_q, locked_d;
  logic             tok_s;

  assign cat_s = {raw, prev_q};
  assign win_s = 10'(cat_s >> offset_q);
  assign tok_s = is_token(win_q);

  // Next-state logic: token-run search with timed bit slips, or lock supervision.
  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    tmo_d    = tmo_q;
    noc_d    = noc_q;
    offset_d = offset_q;
    case (state_q)
      ST_SEARCH: begin
        noc_d = '0;
        // The CTRL_RUN-th consecutive token wins over a slip in the same cycle.
        if (tok_s && (run_q == RUN_W'(CTRL_RUN - 1))) begin
          state_d = ST_LOCKED;
          run_d   = '0;
          tmo_d   = '0;
        end else begin
          if (tok_s) begin
            run_d = run_q + RUN_W'(1);
          end else begin
            run_d = '0;
          end
          if (tmo_q == TMO_W'(SEARCH_TIMEOUT - 1)) begin
            tmo_d    = '0;
            run_d    = '0;
            offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (tok_s) begin
          noc_d = '0;
        end else if (noc_q == NOC_W'(LOCK_TIMEOUT - 1)) begin
          // Lock lost: resume searching from the current offset.
          state_d = ST_SEARCH;
          noc_d   = '0;
          run_d   = '0;
          tmo_d   = '0;
        end else begin
          noc_d = noc_q + NOC_W'(1);
        end
      end
      default: begin
        state_d = ST_SEARCH;
        run_d   = '0;
        tmo_d   = '0;
        noc_d   = '0;
      end
    endcase
  end

  // Output decode uses the next lock state so the locking word itself decodes as control.
  always_comb begin
    locked_d = (state_d == ST_LOCKED);
    data_d   = 8'h00;
    ctrl_d   = ctrl_q;
    vde_d    = 1'b0;
    if (!locked_d) begin
      ctrl_d = 2'b00;
    end else if (tok_s) begin
      ctrl_d = token_value(win_q);
    end else begin
      vde_d  = 1'b1;
      data_d = decode_word(win_q);
    end
  end

  // Pipeline, FSM, counters and output registers.
  always_ff @(posedge pixclk or negedge resetn) begin
    if (!resetn) begin
      prev_q   <= 10'd0;
      win_q    <= 10'd0;
      state_q  <= ST_SEARCH;
      run_q    <= '0;
      tmo_q    <= '0;
      noc_q    <= '0;
      offset_q <= 4'd0;
      data_q   <= 8'h00;
      ctrl_q   <= 2'b00;
      vde_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      prev_q   <= raw;
      win_q    <= win_s;
      state_q  <= state_d;
      run_q    <= run_d;
      tmo_q    <= tmo_d;
      noc_q    <= noc_d;
      offset_q <= offset_d;
      data_q   <= data_d;
      ctrl_q   <= ctrl_d;
      vde_q    <= vde_d;
      locked_q <= locked_d;
    end
  end

  assign data   = data_q;
  assign ctrl   = ctrl_q;
  assign vde    = vde_q;
  assign locked = locked_q;
  assign offset = offset_q;

endmodule

// File: tb/tb_tmds_channel_rx.sv
// Self-checking bench for tmds_channel_rx: a bit-stream reference model compared every
// cycle, a table of aligned words, and directed lock/timeout/slip/reset sequences.
module tb_tmds_channel_rx;

  localparam int CR = 8;
  localparam int ST = 64;
  localparam int LT = 128;

  logic       pixclk = 1'b0;
  logic       resetn = 1'b0;
  logic [9:0] raw    = 10'd0;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       vde;
  logic       locked;
  logic [3:0] offset;

  tmds_channel_rx #(.CTRL_RUN(CR), .SEARCH_TIMEOUT(ST), .LOCK_TIMEOUT(LT)) dut (
    .pixclk (pixclk),
    .resetn (resetn),
    .raw    (raw),
    .data   (data),
    .ctrl   (ctrl),
    .vde    (vde),
    .locked (locked),
    .offset (offset)
  );

  always #5 pixclk = ~pixclk;

  int checks = 0;
  int errors = 0;

  // Reference model state: line bit history, aligned word, counters as plain integers.
  bit         bitq[$];
  logic [9:0] m_win;
  bit         m_locked;
  int         m_run, m_tmo, m_noc, m_off;
  logic [7:0] e_data;
  logic [1:0] e_ctrl;
  bit         e_vde, e_locked;
  int         e_off;

  typedef struct {
    logic [7:0] din;
    bit         use_xor;
    bit         inv;
    bit         is_tok;
    logic [1:0] tok;
    bit         exp_vde;
    logic [7:0] exp_data;
    logic [1:0] exp_ctrl;
  } vec_t;
  vec_t vecs[10];

  function automatic logic [9:0] tok_word(input int c);
    case (c)
      0:       return 10'b1101010100;
      1:       return 10'b0010101011;
      2:       return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  function automatic int tok_of(input logic [9:0] w);
    for (int i = 0; i < 4; i++) if (w == tok_word(i)) return i;
    return -1;
  endfunction

  // Transmitter-side encoding: transition chain, then optional inversion.
  function automatic logic [9:0] encode(input logic [7:0] d, input bit use_xor, input bit inv);
    logic [7:0] qm;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xor ? (qm[i-1] ^ d[i]) : ~(qm[i-1] ^ d[i]);
    return {inv, use_xor, inv ? ~qm : qm};
  endfunction

  // A data bit is 1 when neighbouring chain bits differ in XOR mode, agree in XNOR mode.
  function automatic logic [7:0] m_decode(input logic [9:0] w);
    logic [7:0] qm;
    logic [7:0] d;
    qm   = w[9] ? ~w[7:0] : w[7:0];
    d[0] = qm[0];
    for (int i = 1; i < 8; i++) d[i] = ((qm[i] != qm[i-1]) == w[8]);
    return d;
  endfunction

  function automatic logic [9:0] rand_data_word();
    logic [9:0] w;
    do begin
      w = encode(8'($urandom), 1'($urandom), 1'($urandom));
    end while (tok_of(w) >= 0);
    return w;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    bitq.delete();
    for (int k = 0; k < 10; k++) bitq.push_back(1'b0);
    m_win = 10'd0; m_locked = 1'b0;
    m_run = 0; m_tmo = 0; m_noc = 0; m_off = 0;
    e_data = 8'h00; e_ctrl = 2'b00; e_vde = 1'b0; e_locked = 1'b0; e_off = 0;
  endtask

  task automatic model_step(input logic [9:0] w);
    int         t;
    int         off_old;
    logic [9:0] nw;
    t       = tok_of(m_win);
    off_old = m_off;
    if (!m_locked) begin
      if (t >= 0 && m_run == CR - 1) begin
        m_locked = 1'b1; m_run = 0; m_tmo = 0; m_noc = 0;
      end else begin
        m_run = (t >= 0) ? m_run + 1 : 0;
        if (m_tmo == ST - 1) begin
          m_tmo = 0; m_run = 0; m_off = (m_off + 1) % 10;
        end else begin
          m_tmo++;
        end
      end
    end else begin
      if (t >= 0) m_noc = 0;
      else if (m_noc == LT - 1) begin
        m_locked = 1'b0; m_noc = 0; m_run = 0; m_tmo = 0;
      end else m_noc++;
    end
    if (!m_locked) begin
      e_vde = 1'b0; e_data = 8'h00; e_ctrl = 2'b00;
    end else if (t >= 0) begin
      e_vde = 1'b0; e_data = 8'h00; e_ctrl = 2'(t);
    end else begin
      e_vde = 1'b1; e_data = m_decode(m_win);
    end
    e_locked = m_locked;
    e_off    = m_off;
    for (int k = 0; k < 10; k++) bitq.push_back(w[k]);
    for (int k = 0; k < 10; k++) nw[k] = bitq[off_old + k];
    repeat (10) void'(bitq.pop_front());
    m_win = nw;
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_data"},   int'(data),   int'(e_data));
    check({tag, "_ctrl"},   int'(ctrl),   int'(e_ctrl));
    check({tag, "_vde"},    int'(vde),    int'(e_vde));
    check({tag, "_locked"}, int'(locked), int'(e_locked));
    check({tag, "_offset"}, int'(offset), e_off);
  endtask

  // One pixel clock: drive a word, advance the model at the edge, compare just after.
  task automatic tick(input logic [9:0] w);
    raw = w;
    @(posedge pixclk);
    if (resetn) model_step(w);
    else model_reset();
    #1;
    compare_all("model");
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    model_reset();
    #1;
    compare_all("rst_async");
    repeat (4) tick(10'($urandom));
    resetn = 1'b1;
  endtask

  int         n;
  logic [9:0] w;
  bit         sbits[$];

  initial begin
    vecs[0] = '{8'h55, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 8'h55, 2'd1};
    vecs[1] = '{8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 8'h00, 2'd1};
    vecs[2] = '{8'h00, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 8'h00, 2'd3};
    vecs[3] = '{8'hA7, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 8'hA7, 2'd3};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 8'hFF, 2'd3};
    vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 8'h00, 2'd0};
    vecs[6] = '{8'h00, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 8'h00, 2'd2};
    vecs[7] = '{8'h3C, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 8'h3C, 2'd2};
    vecs[8] = '{8'h81, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 8'h81, 2'd2};
    vecs[9] = '{8'h00, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 8'h00, 2'd1};

    // Reset with random input: everything held at zero.
    do_reset();

    // Run of 01 tokens at phase 0: lock appears on the 10th edge after the first token.
    n = 0;
    while (!locked && n < 40) begin
      tick(tok_word(1));
      n++;
    end
    check("lock_latency", n, 10);
    check("lock_ctrl", int'(ctrl), 1);
    check("lock_vde", int'(vde), 0);
    check("lock_offset", int'(offset), 0);

    // Table of aligned words; each shows up on the outputs two ticks after it is driven.
    for (int i = 0; i < 12; i++) begin
      if (i < 10) w = vecs[i].is_tok ? tok_word(int'(vecs[i].tok))
                                     : encode(vecs[i].din, vecs[i].use_xor, vecs[i].inv);
      else w = tok_word(1);
      tick(w);
      if (i >= 2) begin
        check($sformatf("tbl%0d_vde", i - 2),  int'(vde),  int'(vecs[i-2].exp_vde));
        check($sformatf("tbl%0d_data", i - 2), int'(data), int'(vecs[i-2].exp_data));
        check($sformatf("tbl%0d_ctrl", i - 2), int'(ctrl), int'(vecs[i-2].exp_ctrl));
      end
    end

    // Lock timeout: only data words; lock drops when the LT-th one is evaluated.
    repeat (3) tick(tok_word(1));
    n = 0;
    while (locked && n < 3 * LT) begin
      tick(rand_data_word());
      n++;
    end
    check("unlock_latency", n, LT + 2);
    check("unlock_offset", int'(offset), 0);
    check("unlock_vde", int'(vde), 0);

    // Search without tokens: a slip every ST cycles, 0..9 then wrap to 0.
    do_reset();
    for (int s = 1; s <= 11; s++) begin
      repeat (ST - 1) tick(10'd0);
      check($sformatf("slip%0d_before", s), int'(offset), (s - 1) % 10);
      tick(10'd0);
      check($sformatf("slip%0d_after", s), int'(offset), s % 10);
    end

    // Encoded line stream rotated by 7 bits: alignment settles at offset 7.
    do_reset();
    sbits.delete();
    for (int k = 0; k < 7; k++) sbits.push_back(1'($urandom));
    for (int line = 0; line < 14; line++) begin
      w = tok_word(int'($urandom_range(0, 3)));
      for (int j = 0; j < 20; j++) for (int k = 0; k < 10; k++) sbits.push_back(w[k]);
      for (int j = 0; j < 28; j++) begin
        w = rand_data_word();
        for (int k = 0; k < 10; k++) sbits.push_back(w[k]);
      end
    end
    while (sbits.size() >= 10) begin
      for (int k = 0; k < 10; k++) w[k] = sbits.pop_front();
      tick(w);
    end
    check("rot_offset", int'(offset), 7);
    check("rot_locked", int'(locked), 1);

    // Reset mid-lock: outputs clear without waiting for a clock edge.
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check("amid_locked", int'(locked), 0);
    check("amid_offset", int'(offset), 0);
    compare_all("amid");
    repeat (3) tick(10'($urandom));
    resetn = 1'b1;
    repeat (5) tick(tok_word(2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
